// File: rtl/bar_arb_pkg.sv
// Shared types for the bar round-robin arbiter.
// Source ids, burst counter width and lock state.
package bar_arb_pkg;
    localparam int NUM_SRC = 4;

    typedef logic [1:0] src_id_t;
    typedef logic [7:0] burst_cnt_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;
endpackage

// File: rtl/bar.sv
// Valid/ready stream bundle with a configurable valid type.
// The arbiter sees producers through in and the consumer through out.
interface bar #(
    parameter int  N = 32,
    parameter type T = logic
);
    logic [N-1:0] data;
    T             valid;
    logic         ready;

    modport in  (input data, input valid, output ready);
    modport out (output data, output valid, input ready);
endinterface

// File: rtl/bar_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr.
// The request vector is doubled and shifted so bit 0 is req[ptr].
module bar_rr_pick
    import bar_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  src_id_t            ptr,
    output src_id_t            gnt_id,
    output logic               any
);
    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;

    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_SRC-1:0];
    assign any = |rot;

    always_comb begin
        gnt_id = '0;
        priority case (1'b1)
            rot[0]:  gnt_id = ptr;
            rot[1]:  gnt_id = ptr + 2'd1;
            rot[2]:  gnt_id = ptr + 2'd2;
            rot[3]:  gnt_id = ptr + 2'd3;
            default: gnt_id = '0;
        endcase
    end
endmodule

// File: rtl/bar_arbiter.sv
// Four-way round-robin bar arbiter with burst lock
// and a one-entry registered output stage.
module bar_arbiter
    import bar_arb_pkg::*;
#(
    parameter int  N     = 32,
    parameter type T     = logic,
    parameter int  BURST = 1
) (
    input  logic    clk,
    input  logic    rst,
    bar.in          s0,
    bar.in          s1,
    bar.in          s2,
    bar.in          s3,
    bar.out         m,
    output src_id_t grant_id,
    output logic    busy
);
    arb_state_t state, state_nxt;
    src_id_t    ptr, ptr_nxt;
    src_id_t    gnt_q, gnt_nxt;
    src_id_t    pick, grant;
    burst_cnt_t cnt, cnt_nxt, cnt_inc;

    logic [NUM_SRC-1:0] req;
    logic               any, has_grant, space, rdy_en, accept;
    logic               sel_req;
    logic [N-1:0]       sel_data;
    T                   sel_valid;

    logic               out_full;
    logic [N-1:0]       out_data;
    T                   out_valid;

    assign req[0] = s0.valid != '0;
    assign req[1] = s1.valid != '0;
    assign req[2] = s2.valid != '0;
    assign req[3] = s3.valid != '0;

    bar_rr_pick u_pick (
        .req    (req),
        .ptr    (ptr),
        .gnt_id (pick),
        .any    (any)
    );

    assign grant     = (state == GRANT) ? gnt_q : pick;
    assign has_grant = (state == GRANT) || any;

    always_comb begin
        sel_data  = s0.data;
        sel_valid = s0.valid;
        unique case (grant)
            2'd0: begin
                sel_data  = s0.data;
                sel_valid = s0.valid;
            end
            2'd1: begin
                sel_data  = s1.data;
                sel_valid = s1.valid;
            end
            2'd2: begin
                sel_data  = s2.data;
                sel_valid = s2.valid;
            end
            2'd3: begin
                sel_data  = s3.data;
                sel_valid = s3.valid;
            end
        endcase
    end

    assign sel_req = sel_valid != '0;
    assign space   = !out_full || m.ready;
    assign rdy_en  = !rst && has_grant && space;
    assign accept  = rdy_en && sel_req;

    assign s0.ready = rdy_en && (grant == 2'd0);
    assign s1.ready = rdy_en && (grant == 2'd1);
    assign s2.ready = rdy_en && (grant == 2'd2);
    assign s3.ready = rdy_en && (grant == 2'd3);

    assign cnt_inc = cnt + 8'd1;

    // Quota exhausted or the locked source went idle: rotate past it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_q;
        if (accept) begin
            if (cnt_inc == burst_cnt_t'(BURST)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                ptr_nxt   = grant + 2'd1;
            end else begin
                state_nxt = GRANT;
                cnt_nxt   = cnt_inc;
                gnt_nxt   = grant;
            end
        end else if (state == GRANT && !sel_req) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            ptr_nxt   = grant + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gnt_q     <= '0;
            out_full  <= 1'b0;
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            gnt_q <= gnt_nxt;
            if (accept) begin
                out_full  <= 1'b1;
                out_data  <= sel_data;
                out_valid <= sel_valid;
            end else if (out_full && m.ready) begin
                out_full <= 1'b0;
            end
        end
    end

    assign m.data   = out_data;
    assign m.valid  = out_full ? out_valid : '0;
    assign busy     = out_full;
    assign grant_id = (!rst && has_grant) ? grant : '0;
endmodule

// File: tb/tb_bar_arbiter.sv
// Bench for bar_arbiter: directed scenarios then random traffic,
// two instances (BURST=1 logic valid, BURST=3 byte valid) vs a reference model.
module tb_bar_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bar #(.N(32), .T(logic)) a0(), a1(), a2(), a3(), am();
    bar #(.N(19), .T(byte))  b0(), b1(), b2(), b3(), bm();

    logic [31:0] ad[4];
    logic        av[4];
    logic [18:0] bd[4];
    byte         bv[4];
    logic        amr, bmr;
    logic        ar[4], br[4];
    logic [1:0]  ag, bg;
    logic        abusy, bbusy;
    logic        amv;
    byte         bmv;

    assign a0.data = ad[0]; assign a0.valid = av[0];
    assign a1.data = ad[1]; assign a1.valid = av[1];
    assign a2.data = ad[2]; assign a2.valid = av[2];
    assign a3.data = ad[3]; assign a3.valid = av[3];
    assign b0.data = bd[0]; assign b0.valid = bv[0];
    assign b1.data = bd[1]; assign b1.valid = bv[1];
    assign b2.data = bd[2]; assign b2.valid = bv[2];
    assign b3.data = bd[3]; assign b3.valid = bv[3];
    assign ar[0] = a0.ready; assign ar[1] = a1.ready;
    assign ar[2] = a2.ready; assign ar[3] = a3.ready;
    assign br[0] = b0.ready; assign br[1] = b1.ready;
    assign br[2] = b2.ready; assign br[3] = b3.ready;
    assign am.ready = amr;
    assign bm.ready = bmr;
    assign amv = am.valid;
    assign bmv = bm.valid;

    bar_arbiter #(.N(32), .T(logic), .BURST(1)) ua (
        .clk(clk), .rst(rst),
        .s0(a0), .s1(a1), .s2(a2), .s3(a3),
        .m(am), .grant_id(ag), .busy(abusy)
    );

    bar_arbiter #(.N(19), .T(byte), .BURST(3)) ub (
        .clk(clk), .rst(rst),
        .s0(b0), .s1(b1), .s2(b2), .s3(b3),
        .m(bm), .grant_id(bg), .busy(bbusy)
    );

    int checks = 0;
    int errors = 0;

    int          m_ptr[2], m_cnt[2], m_gnt[2], m_val[2];
    bit          m_lock[2], m_full[2];
    logic [31:0] m_data[2];
    int          burst[2];
    bit          lastr[2][4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int vget(int d, int i);
        return (d == 0) ? int'({31'b0, av[i]}) : int'({24'b0, bv[i]});
    endfunction

    function automatic logic [31:0] dget(int d, int i);
        return (d == 0) ? ad[i] : {13'b0, bd[i]};
    endfunction

    function automatic bit mrd(int d);
        return (d == 0) ? amr : bmr;
    endfunction

    function automatic logic [31:0] rdy(int d, int i);
        return (d == 0) ? {31'b0, ar[i]} : {31'b0, br[i]};
    endfunction

    task automatic model_reset(int d);
        m_ptr[d] = 0; m_cnt[d] = 0; m_gnt[d] = 0; m_val[d] = 0;
        m_lock[d] = 0; m_full[d] = 0; m_data[d] = '0;
    endtask

    task automatic release_grant(int d, int who);
        m_lock[d] = 0;
        m_cnt[d]  = 0;
        m_ptr[d]  = (who + 1) % 4;
    endtask

    // Check both instances against the model, advance it, cross one edge.
    task automatic step();
        #2;
        for (int d = 0; d < 2; d++) begin
            int who;
            bit room;
            bit exp_r;
            int n;
            logic [31:0] gid, mv, md, bz;
            who = -1;
            if (m_lock[d]) who = m_gnt[d];
            else begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_ptr[d] + k) % 4;
                    if (who < 0 && vget(d, idx) != 0) who = idx;
                end
            end
            room = !m_full[d] || mrd(d);
            for (int i = 0; i < 4; i++) begin
                exp_r = !rst && who == i && room;
                lastr[d][i] = exp_r;
                chk($sformatf("ready_d%0d_s%0d", d, i), rdy(d, i), {31'b0, exp_r});
            end
            gid = (d == 0) ? {30'b0, ag} : {30'b0, bg};
            mv  = (d == 0) ? {31'b0, amv} : {24'b0, bmv};
            md  = (d == 0) ? am.data : {13'b0, bm.data};
            bz  = (d == 0) ? {31'b0, abusy} : {31'b0, bbusy};
            chk($sformatf("grant_id_d%0d", d), gid,
                (!rst && who >= 0) ? who : 0);
            chk($sformatf("m_valid_d%0d", d), mv, m_full[d] ? m_val[d] : 0);
            chk($sformatf("m_data_d%0d", d), md, m_data[d]);
            chk($sformatf("busy_d%0d", d), bz, {31'b0, m_full[d]});

            if (rst) model_reset(d);
            else if (who >= 0 && room && vget(d, who) != 0) begin
                m_full[d] = 1;
                m_data[d] = dget(d, who);
                m_val[d]  = vget(d, who);
                n = m_cnt[d] + 1;
                if (n == burst[d]) release_grant(d, who);
                else begin
                    m_lock[d] = 1;
                    m_cnt[d]  = n;
                    m_gnt[d]  = who;
                end
            end else begin
                if (m_full[d] && mrd(d)) m_full[d] = 0;
                if (m_lock[d] && vget(d, who) == 0) release_grant(d, who);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        burst[0] = 1;
        burst[1] = 3;
        model_reset(0);
        model_reset(1);
        rst = 1'b1;
        amr = 1'b1;
        bmr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            av[i] = 1'b1;
            ad[i] = 32'h100 + i;
            bd[i] = 19'h10 + i;
            bv[i] = 8'h00;
        end
        bv[1] = 8'h21;
        bv[2] = 8'h22;

        // First edge puts both instances into their reset state.
        @(posedge clk);
        #1;
        step();
        step();

        rst = 1'b0;
        #1;
        chk("first_ready_s0", {31'b0, ar[0]}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("burst_gid", {30'b0, bg}, (k < 3) ? 32'd1 : 32'd2);
            step();
            if (k < 5) chk("fair_data", am.data, 32'h100 + (k % 4));
        end

        for (int i = 0; i < 4; i++) av[i] = 1'b0;
        av[0] = 1'b1;
        ad[0] = 32'hDEAD;
        step();
        amr = 1'b0;
        ad[0] = 32'hBEEF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_data", am.data, 32'hDEAD);
            chk("bp_valid", {31'b0, amv}, 32'h1);
            chk("bp_ready", {31'b0, ar[0]}, 32'h0);
            step();
        end
        amr = 1'b1;
        #1;
        chk("bp_resume_ready", {31'b0, ar[0]}, 32'h1);
        step();
        chk("bp_no_gap", am.data, 32'hBEEF);
        chk("bp_no_gap_v", {31'b0, amv}, 32'h1);
        av[0] = 1'b0;

        for (int i = 0; i < 4; i++) bv[i] = 8'h00;
        bv[3] = 8'h5A;
        bd[3] = 19'h51234;
        for (int k = 0; k < 4; k++) step();
        chk("pass_valid", {24'b0, bmv}, 32'h5A);
        chk("pass_data", {13'b0, bm.data}, 32'h51234);

        bv[3] = 8'h00;
        for (int k = 0; k < 3; k++) step();
        bv[1] = 8'h33;
        bd[1] = 19'h00333;
        step();
        chk("mid_beat1", {24'b0, bmv}, 32'h33);
        rst = 1'b1;
        bv[0] = 8'h77;
        step();
        chk("mid_rst_valid", {24'b0, bmv}, 32'h0);
        rst = 1'b0;
        #1;
        chk("ptr_reset_s0", {31'b0, br[0]}, 32'h1);
        step();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(av[i] != 1'b0 && !lastr[0][i])) begin
                    av[i] = 1'($urandom_range(0, 1));
                    ad[i] = $urandom;
                end
                if (!(bv[i] != 8'h00 && !lastr[1][i])) begin
                    bv[i] = ($urandom_range(0, 1) == 1) ? byte'($urandom) : 8'h00;
                    bd[i] = 19'($urandom);
                end
            end
            amr = ($urandom_range(0, 3) != 0);
            bmr = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bar_arbiter.md
# bar_arbiter

Round-robin arbiter that shares one downstream `bar` consumer between four upstream `bar` producers. Each producer connects through a `bar.in` modport port and the consumer through a `bar.out` modport port. A one-entry registered output stage decouples the downstream `ready` from the upstream `ready`. A configurable burst quota lets a granted source send several consecutive beats before the grant rotates.

## Interface

Parameters:
- `N`, default 32: payload width; must match `N` of every connected `bar` instance.
- `T`, default `logic`: valid type; must match `T` of every connected `bar` instance.
- `BURST`, default 1: maximum consecutive accepted beats per grant, range 1..255.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `s0`..`s3`  interface  `bar.in`  producer ports: `data`/`valid` inputs, `ready` output.
- `m`  interface  `bar.out`  consumer port: `data`/`valid` outputs, `ready` input.
- `grant_id`  output  2  index of the currently granted source; 0 when no source is granted.
- `busy`  output  1  output register holds a beat.

## Operation

- Source *i* is requesting when `si.valid != '0`. The full `T` value is stored and forwarded unchanged.
- Output register: `out_full`, `out_data[N-1:0]`, `out_valid` (type T). `m.data = out_data`; `m.valid = out_full ? out_valid : '0`.
- Drain: `out_full && m.ready` → beat leaves the register.
- Space: `space = !out_full || m.ready`.
- Grant selection: when not locked, pick the first requesting source scanning `ptr`, `ptr+1`, … mod 4. The grant is combinational from current requests.
- Accept: `si.ready = !rst && (grant == i) && space`. All other `ready` outputs are 0. Accept on `si.valid != '0 && si.ready` loads the register and sets `out_full`.
- Drain and accept in the same cycle: the register is reloaded and `out_full` stays 1, giving full throughput.
- Lock and burst:
  - On accept, `lock = 1` and `cnt++`.
  - If `cnt` reaches `BURST`, or the granted source deasserts valid in a cycle without an accept, set `lock = 0`, `cnt = 0`, `ptr = grant + 1`.
  - While locked, the grant stays fixed even if higher-priority sources request.
- States: IDLE (`!lock`, no grant), GRANT (`lock`, `cnt < BURST`). IDLE → GRANT on first accept; GRANT → IDLE on quota exhausted or source idle.
- Sources must hold `data`/`valid` stable while `ready` is low. The arbiter does not check this.
- `busy = out_full`.

## Timing

- Latency: an accepted beat appears on `m` the next cycle.
- Throughput: 1 beat/cycle while `m.ready` is held high.
- Reset values: `m.valid = '0`, `m.data = '0`, all `si.ready = 0`, `grant_id = 0`, `busy = 0`, `ptr = 0`, `cnt = 0`, `lock = 0`.
- Reset asserted mid-transfer: the buffered beat is discarded and the quota is cleared. No `ready` is asserted during `rst`.
- Backpressure: `m.ready` low with the register full → all `si.ready = 0` in that cycle. The grant and lock hold.
- `ptr` wraps from 3 to 0.
- With `BURST = 1` and all sources valid continuously, the grant order is 0,1,2,3,0,…

## Structure

- Package `bar_arb_pkg`:
  - `localparam int NUM_SRC = 4`
  - `typedef logic [1:0] src_id_t`
  - `typedef logic [7:0] burst_cnt_t`
- Sub-module `bar_rr_pick`: combinational, inputs `req[3:0]` and `ptr`; outputs `gnt_id` and `any`. It is the rotate-priority picker.
- The top holds the lock/count FSM and the output register.

## Test plan

- Reset: hold `rst` 3 cycles with all sources valid → all `ready = 0` and `m.valid = 0`. First `ready` rises on `s0` in the cycle after `rst` falls.
- Fairness, `BURST = 1`, `m.ready = 1`, all four valid with data `0x100+i` → `m.data` sequence `0x100, 0x101, 0x102, 0x103, 0x100`, one per cycle after 1-cycle latency.
- Burst, `BURST = 3`: `s1` and `s2` valid continuously → 3 beats from `s1`, then 3 from `s2`. `grant_id` sequence `1,1,1,2,2,2`.
- Backpressure: `m.ready = 0` for 4 cycles with a beat `0xDEAD` buffered → `m.data` holds `0xDEAD`, `m.valid` holds, every `si.ready = 0`. When `m.ready` returns to 1, the next beat follows with no gap.
- Type passthrough: instantiate with `N = 19`, `T = byte`, `s3.valid = 8'h5A` → `m.valid = 8'h5A` and `m.data` equals the 19-bit payload.
- Mid-burst reset: `rst` asserted after 1 of 3 beats → `m.valid = 0` next cycle. `ptr = 0` afterwards, so `s0` wins if valid.
